// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one partial product per cycle.
// One 2*WIDTH-bit adder serves all iterations. Latency WIDTH+1 cycles from the
// edge that accepts start.
//
// Build option: define SEQ_MULT_SIGNED_EN for two's-complement operands.
// Without it the datapath is purely unsigned.
//
// Handshake: start is accepted on a rising clk edge whenever busy=0 (IDLE or
// DONE). Operands a/b need only be valid at that edge. valid is a one-cycle
// strobe that marks the cycle in which product first shows the new result.
// product then holds until the next strobe. start is ignored while busy=1.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               start,
  output logic [2*WIDTH-1:0] product,
  output logic               valid,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [4:0]       cnt;

  logic             accept;
  logic             last_iter;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;

  // A new operation may start from IDLE or from DONE, which gives back-to-back issue.
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (cnt == 5'(WIDTH - 1));
  assign busy      = (state == RUN);
  assign state_dbg = state;
  assign addend    = mplier[0] ? mcand : '0;

`ifdef SEQ_MULT_SIGNED_EN
  // Sign-extend the multiplicand. The multiplier MSB has negative weight, so
  // the last iteration subtracts its partial product.
  assign a_ext    = {{WIDTH{a[WIDTH-1]}}, a};
  assign acc_next = last_iter ? (acc - addend) : (acc + addend);
`else
  // Unsigned: zero-extend and always add.
  assign a_ext    = {{WIDTH{1'b0}}, a};
  assign acc_next = acc + addend;
`endif

  // Control FSM and datapath registers. Reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= a_ext;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (last_iter) begin
            state <= DONE;
          end
        end
        DONE: begin
          product <= acc;
          valid   <= 1'b1;
          if (accept) begin
            mcand  <= a_ext;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier with WIDTH=4.
// Expected products are hand-computed. The signed build selects its own constants.
module tb_seq_multiplier;

  localparam int W = 4;

  logic           clk;
  logic           reset;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           start;
  logic [2*W-1:0] product;
  logic           valid;
  logic           busy;
  logic [1:0]     state_dbg;

  int checks;
  int errors;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .start     (start),
    .product   (product),
    .valid     (valid),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Full single operation with cycle-exact handshake checks.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] exp_p);
    a = av;
    b = bv;
    start = 1'b1;
    tick();                              // E0 accepts
    start = 1'b0;
    a = $urandom_range(0, 15);           // operands only matter at E0
    b = $urandom_range(0, 15);
    check({tag, "_busy_e0"}, 16'(busy), 16'd1);
    for (int i = 1; i < W; i++) begin
      tick();
      check({tag, "_busy_run"}, 16'(busy), 16'd1);
      check({tag, "_valid_run"}, 16'(valid), 16'd0);
    end
    tick();                              // E4: DONE
    check({tag, "_busy_done"}, 16'(busy), 16'd0);
    check({tag, "_valid_done"}, 16'(valid), 16'd0);
    tick();                              // E5: result visible
    check({tag, "_valid"}, 16'(valid), 16'd1);
    check({tag, "_product"}, 16'(product), 16'(exp_p));
    tick();
    check({tag, "_valid_off"}, 16'(valid), 16'd0);
    check({tag, "_hold"}, 16'(product), 16'(exp_p));
  endtask

  logic [2*W-1:0] exp_1x15;
  logic [2*W-1:0] exp_15x15;
  int             vcount;

  initial begin
    checks = 0;
    errors = 0;
`ifdef SEQ_MULT_SIGNED_EN
    exp_1x15  = 8'hFF;                   // 1 * -1
    exp_15x15 = 8'h01;                   // -1 * -1
`else
    exp_1x15  = 8'h0F;
    exp_15x15 = 8'hE1;
`endif
    reset = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) tick();
    check("rst_product", 16'(product), 16'h0);
    check("rst_valid", 16'(valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_state", 16'(state_dbg), 16'd0);
    reset = 1'b1;
    tick();

    // Basic operation, then product held while idle
    run_op("m1x15", 4'd1, 4'd15, exp_1x15);
    repeat (3) tick();
    check("idle_hold", 16'(product), 16'(exp_1x15));
    check("idle_state", 16'(state_dbg), 16'd0);

    run_op("m15x15", 4'd15, 4'd15, exp_15x15);
    run_op("m8x8", 4'h8, 4'h8, 8'h40);
    run_op("m0x13", 4'd0, 4'd13, 8'h00);
    run_op("m5x5", 4'd5, 4'd5, 8'h19);
    run_op("m9x0", 4'd9, 4'd0, 8'h00);

    // start while busy is ignored: exactly one valid with product 3*5
    a = 4'd3;
    b = 4'd5;
    start = 1'b1;
    tick();                              // E0
    start = 1'b0;
    tick();                              // E1
    a = 4'd7;
    b = 4'd7;
    start = 1'b1;
    tick();                              // E2 (busy, ignored)
    start = 1'b0;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid) begin
        vcount++;
        check("ign_product", 16'(product), 16'h0F);
      end
      tick();
    end
    check("ign_valid_count", 16'(vcount), 16'd1);

    // start held high: a result every 5 cycles, a changed mid-run
    a = 4'd2;
    b = 4'd3;
    start = 1'b1;
    tick();                              // t=0 accept
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (t == 6) a = 4'd4;
      check("hold_valid", 16'(valid), 16'((t % 5) == 0));
      check("hold_busy", 16'(busy), 16'((t % 5) != 4));
      if (t == 5 || t == 10) check("hold_p6", 16'(product), 16'h06);
      if (t == 15) check("hold_p12", 16'(product), 16'h0C);
    end
    start = 1'b0;
    repeat (5) tick();                   // drain run accepted at t=15
    check("drain_valid", 16'(valid), 16'd1);
    check("drain_product", 16'(product), 16'h0C);

    // Asynchronous reset after two iterations
    a = 4'd15;
    b = 4'd15;
    start = 1'b1;
    tick();                              // E0
    start = 1'b0;
    tick();                              // E1
    tick();                              // E2
    #2;
    reset = 1'b0;
    #1;
    check("arst_product", 16'(product), 16'h0);
    check("arst_valid", 16'(valid), 16'd0);
    check("arst_busy", 16'(busy), 16'd0);
    tick();
    #2;
    reset = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid) vcount++;
    end
    check("arst_no_valid", 16'(vcount), 16'd0);
    check("arst_state", 16'(state_dbg), 16'd0);

    // Recovers normally after reset
    run_op("m6x7", 4'd6, 4'd7, 8'h2A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
